// File: rtl/imem_prog_loader_pkg.sv
// Shared constants and the loader state type for the mips32 instruction-memory loader.
package mips32_pkg;

  localparam int          IMEM_AW    = 10;
  localparam logic [5:0]  HLT_OPCODE = 6'h3F;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_prog_loader_if.sv
// Word stream into the loader: a word moves when s_valid && s_ready are both high at a
// rising clock edge; s_data/s_last are don't-care whenever s_valid is low.
interface imem_prog_loader_if #(
  parameter int DW = 32
) ();

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/imem_prog_loader_cksum.sv
// Running mod-2**DW sum of the words written in a session, compared against the
// checksum word that closes the stream.
module loader_cksum #(
  parameter int DW = 32
) (
  input  logic          clk_x,
  input  logic          rst,
  input  logic          clr,
  input  logic          acc_en,
  input  logic [DW-1:0] acc_data,
  input  logic [DW-1:0] chk_data,
  output logic          match
);

  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (acc_en) begin
      sum_d = sum_q + acc_data;
    end
  end

  always_ff @(posedge clk_x or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == chk_data);

endmodule

// File: rtl/imem_prog_loader.sv
// Streams a program into instruction memory and holds the core until it is complete.
// Define IMEM_LOADER_CKSUM_EN to treat the s_last word as a checksum instead of an instruction.
module imem_prog_loader
  import mips32_pkg::*;
#(
  parameter int AW        = IMEM_AW,
  parameter int BASE_ADDR = 1,
  parameter int DW        = 32
) (
  input  logic            clk_x,
  input  logic            rst,
  input  logic            start,
  imem_prog_loader_if.slave s,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [DW-1:0]   imem_wdata,
  output logic            core_hold,
  output logic            load_done,
  output logic            load_err,
  output logic [AW:0]     word_cnt,
  output loader_state_e   dbg_state
);

  localparam logic [AW:0]   BASE      = BASE_ADDR[AW:0];
  localparam logic [AW:0]   ONE       = {{AW{1'b0}}, 1'b1};
  localparam logic [DW-1:0] WDATA_RST = DW'(NOP);

  loader_state_e state_q, state_d;
  // addr_q carries one spare bit so a target past the top of imem is visible as overflow.
  logic [AW:0]   addr_q, addr_d;
  logic [AW:0]   tgt;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          xfer;

`ifdef IMEM_LOADER_CKSUM_EN
  logic sess_clr;
  logic acc_en;
  logic cksum_ok;

  loader_cksum #(.DW(DW)) u_cksum (
    .clk_x    (clk_x),
    .rst      (rst),
    .clr      (sess_clr),
    .acc_en   (acc_en),
    .acc_data (s.s_data),
    .chk_data (s.s_data),
    .match    (cksum_ok)
  );
`endif

  assign xfer = s.s_valid && (state_q == LOAD);
  // Address the next accepted word lands on: one past any write still in flight.
  assign tgt  = addr_q + {{AW{1'b0}}, we_q};

  always_comb begin
    state_d = state_q;
    addr_d  = tgt;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = (state_q == DONE);
`ifdef IMEM_LOADER_CKSUM_EN
    sess_clr = 1'b0;
    acc_en   = 1'b0;
`endif
    case (state_q)
      LOAD: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
          if (s.s_last) begin
            state_d = cksum_ok ? DONE : ERR;
          end else if (tgt[AW]) begin
            state_d = ERR;
          end else begin
            we_d    = 1'b1;
            wdata_d = s.s_data;
            cnt_d   = cnt_q + ONE;
            acc_en  = 1'b1;
          end
`else
          if (tgt[AW]) begin
            state_d = ERR;
          end else begin
            we_d    = 1'b1;
            wdata_d = s.s_data;
            cnt_d   = cnt_q + ONE;
            if (s.s_last) begin
              state_d = DONE;
            end
          end
`endif
        end
      end
      default: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE;
          cnt_d   = '0;
          done_d  = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
          sess_clr = 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_x or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      we_q    <= 1'b0;
      wdata_q <= WDATA_RST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // done_q lags entry to DONE by a cycle so the core is released only after the last write.
  assign s.s_ready  = (state_q == LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q[AW-1:0];
  assign imem_wdata = wdata_q;
  assign core_hold  = ~done_q;
  assign load_done  = done_q;
  assign load_err   = (state_q == ERR);
  assign word_cnt   = cnt_q;
  assign dbg_state  = state_q;

endmodule
